// File: rtl/instruction_fetch_stage_if.sv
// Fetch-stage bus: control and instruction-memory load inputs, plus the IF/ID outputs.
// The master drives stall, redirect and memory writes. The slave is the fetch stage itself.
interface instruction_fetch_stage_if #(
  parameter int ADDR_W  = 32'd8,
  parameter int OPC_W   = 32'd2,
  parameter int REG_W   = 32'd3,
  parameter int INSTR_W = OPC_W + 2 * REG_W
);
  logic               stall;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_target;
  logic               imem_we;
  logic [ADDR_W-1:0]  imem_waddr;
  logic [INSTR_W-1:0] imem_wdata;
  logic [ADDR_W-1:0]  pc;
  logic               if_valid;
  logic [ADDR_W-1:0]  if_pc;
  logic [OPC_W-1:0]   opcode;
  logic [REG_W-1:0]   rDest;
  logic [REG_W-1:0]   rSrc;
  logic [REG_W-1:0]   immediate_data;
  logic [ADDR_W-1:0]  jump_address;

  modport master (
    output stall, redirect_valid, redirect_target, imem_we, imem_waddr, imem_wdata,
    input  pc, if_valid, if_pc, opcode, rDest, rSrc, immediate_data, jump_address
  );

  modport slave (
    input  stall, redirect_valid, redirect_target, imem_we, imem_waddr, imem_wdata,
    output pc, if_valid, if_pc, opcode, rDest, rSrc, immediate_data, jump_address
  );
endinterface

// File: rtl/instruction_fetch_stage.sv
// Clocked instruction fetch: PC, a loadable instruction memory and the IF/ID pipeline register.
// It supports stall, and a redirect that squashes the wrong-path fetch.
module instruction_fetch_stage #(
  parameter int                ADDR_W   = 32'd8,
  parameter int                OPC_W    = 32'd2,
  parameter int                REG_W    = 32'd3,
  parameter int                INSTR_W  = OPC_W + 2 * REG_W,
  parameter int                DEPTH    = 2 ** ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input logic                      clk,
  input logic                      reset_n,
  instruction_fetch_stage_if.slave bus
);
  localparam int                LOW_W  = INSTR_W - OPC_W;
  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W - 1){1'b0}}, 1'b1};

  if (INSTR_W != OPC_W + 2 * REG_W) begin : g_bad_instr_w
    $error("INSTR_W must equal OPC_W + 2*REG_W");
  end
  if (DEPTH < 1 || DEPTH > 2 ** ADDR_W) begin : g_bad_depth
    $error("DEPTH must be in 1 .. 2**ADDR_W");
  end

  logic [INSTR_W-1:0] imem_q [DEPTH];
  logic [INSTR_W-1:0] fetch_word_s;
  logic [ADDR_W-1:0]  jump_s;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               if_valid_q, if_valid_d;
  logic [ADDR_W-1:0]  if_pc_q, if_pc_d;
  logic [OPC_W-1:0]   opcode_q, opcode_d;
  logic [REG_W-1:0]   rdest_q, rdest_d;
  logic [REG_W-1:0]   rsrc_q, rsrc_d;
  logic [ADDR_W-1:0]  jump_q, jump_d;

  // Memory write has no reset so that contents survive reset and can be loaded while it is held.
  always_ff @(posedge clk) begin
    if (bus.imem_we && (32'(bus.imem_waddr) < DEPTH)) begin
      imem_q[bus.imem_waddr] <= bus.imem_wdata;
    end
  end

  // Combinational read. A same-cycle write lands after the edge, so the fetch sees the old word.
  always_comb begin
    if (32'(pc_q) < DEPTH) begin
      fetch_word_s = imem_q[pc_q];
    end else begin
      fetch_word_s = {INSTR_W{1'b0}};
    end
  end

  if (ADDR_W > LOW_W) begin : g_jump_page
    assign jump_s = {pc_q[ADDR_W-1:LOW_W], fetch_word_s[LOW_W-1:0]};
  end else begin : g_jump_low
    assign jump_s = fetch_word_s[ADDR_W-1:0];
  end

  // Next-state selection. Redirect beats stall, and stall beats a normal fetch.
  always_comb begin
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    opcode_d   = opcode_q;
    rdest_d    = rdest_q;
    rsrc_d     = rsrc_q;
    jump_d     = jump_q;
    if (bus.redirect_valid) begin
      pc_d       = bus.redirect_target;
      if_valid_d = 1'b0;
    end else if (!bus.stall) begin
      pc_d       = pc_q + PC_ONE;
      if_valid_d = 1'b1;
      if_pc_d    = pc_q;
      opcode_d   = fetch_word_s[INSTR_W-1 -: OPC_W];
      rdest_d    = fetch_word_s[2*REG_W-1 -: REG_W];
      rsrc_d     = fetch_word_s[REG_W-1:0];
      jump_d     = jump_s;
    end else begin
      pc_d       = pc_q;
      if_valid_d = if_valid_q;
    end
  end

  // PC and IF/ID pipeline register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_pc_q    <= {ADDR_W{1'b0}};
      opcode_q   <= {OPC_W{1'b0}};
      rdest_q    <= {REG_W{1'b0}};
      rsrc_q     <= {REG_W{1'b0}};
      jump_q     <= {ADDR_W{1'b0}};
    end else begin
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      opcode_q   <= opcode_d;
      rdest_q    <= rdest_d;
      rsrc_q     <= rsrc_d;
      jump_q     <= jump_d;
    end
  end

  assign bus.pc             = pc_q;
  assign bus.if_valid       = if_valid_q;
  assign bus.if_pc          = if_pc_q;
  assign bus.opcode         = opcode_q;
  assign bus.rDest          = rdest_q;
  assign bus.rSrc           = rsrc_q;
  assign bus.immediate_data = rsrc_q;
  assign bus.jump_address   = jump_q;
endmodule
